i2s_axis_codec: RTL and testbench

Parametrised stereo I2S master and AXI4-Stream bridge for CS4344/CS5343-class DAC/ADC pairs such as the Pmod I2S2. It generates MCLK, SCLK and LRCK from one clock, serialises TX packets and deserialises RX frames. Audio width, slot width, SCLK divider and justification mode (I2S or left-justified) are selectable. Compared with the fixed 24-bit/44.1 kHz controller, it adds a double-buffered TX path with no tearing window, RX sign extension, and saturating underflow/overflow counters.

---
 rtl/i2s_axis_codec.sv | 249 ++++++++++++++++++++++++
 tb/tb_i2s_axis_codec.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_axis_codec.sv
// Stereo I2S master with AXI4-Stream TX/RX bridges.
// One clk_mclk domain generates SCLK/LRCK from a frame counter. A
// double-buffered TX pending packet is handed to the serialiser at each
// frame boundary. RX frames are sign-extended and offered as a left/right
// beat pair. Underflow and overflow counters saturate.
module i2s_axis_codec #(
  parameter int unsigned AXI_DATA_WIDTH_P = 32,
  parameter int unsigned AUDIO_WIDTH_P    = 24,
  parameter int unsigned SLOT_BITS_P      = 32,
  parameter int unsigned SCLK_DIV_P       = 8,
  parameter bit          TX_HOLD_P        = 1'b1
) (
  input  logic                        clk_mclk,
  input  logic                        rst,
  input  logic                        cr_enable,
  input  logic                        cr_left_justified,
  input  logic                        cr_clear_status,
  output logic                        tx_mclk,
  output logic                        rx_mclk,
  output logic                        tx_sclk,
  output logic                        rx_sclk,
  output logic                        tx_lrck,
  output logic                        rx_lrck,
  output logic                        tx_sdout,
  input  logic                        rx_sdin,
  input  logic [AXI_DATA_WIDTH_P-1:0] tx_axis_s_data,
  input  logic                        tx_axis_s_valid,
  output logic                        tx_axis_s_ready,
  input  logic                        tx_axis_s_last,
  output logic [AXI_DATA_WIDTH_P-1:0] rx_axis_m_data,
  output logic                        rx_axis_m_valid,
  input  logic                        rx_axis_m_ready,
  output logic                        rx_axis_m_last,
  output logic [15:0]                 sr_tx_underflow_cnt,
  output logic [15:0]                 sr_rx_overflow_cnt,
  output logic                        sr_tx_last_err
);

  localparam int unsigned ADW     = AXI_DATA_WIDTH_P;
  localparam int unsigned AW      = AUDIO_WIDTH_P;
  localparam int unsigned FRAME_C = 2 * SLOT_BITS_P * SCLK_DIV_P;
  localparam int unsigned CNT_W   = $clog2(FRAME_C);
  localparam int unsigned IDX_W   = (AW > 1) ? $clog2(AW) : 1;

  // Saturating 16-bit increment for the status counters.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (&v) ? v : v + 16'd1;
  endfunction

  // Sign-extend an audio sample to the AXIS data width.
  function automatic logic [ADW-1:0] sext(input logic [AW-1:0] v);
    return ADW'($signed(v));
  endfunction

  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic             frame_end_c;
  logic             just_q, just_nxt;
  logic             sclk_q, sclk_nxt, lrck_q, lrck_nxt, sdout_q, sdout_nxt;
  logic [1:0]       rx_sync_q;
  logic [AW-1:0]    tx_l_q, tx_l_nxt, tx_r_q, tx_r_nxt;
  logic [AW-1:0]    pend_l_q, pend_l_nxt, pend_r_q, pend_r_nxt;
  logic             pend_full_q, pend_full_nxt, beat_q, beat_nxt;
  logic             ready_q;
  logic [AW-1:0]    rx_l_q, rx_l_nxt, rx_r_q, rx_r_nxt;
  logic [ADW-1:0]   rx_data_q, rx_data_nxt, rx_hold_q, rx_hold_nxt;
  logic             rx_valid_q, rx_valid_nxt, rx_last_q, rx_last_nxt;
  logic [15:0]      uf_q, uf_nxt, of_q, of_nxt;
  logic             err_q, err_nxt;
  logic             hs_tx_c, hs_rx_c;
  logic             unused_data_c;

  int unsigned ph_n, b_n, s_n, d_n, idx_n;
  int unsigned ph_q, b_q, s_q, d_q;
  logic        win_n, win_q, tx_bit_n, rx_shift_c;
  logic [AW-1:0] tx_word_n;

  assign tx_mclk = clk_mclk;
  assign rx_mclk = clk_mclk;
  assign tx_sclk = sclk_q;
  assign rx_sclk = sclk_q;
  assign tx_lrck = lrck_q;
  assign rx_lrck = lrck_q;
  assign tx_sdout = sdout_q;
  assign tx_axis_s_ready = ready_q;
  assign rx_axis_m_data  = rx_data_q;
  assign rx_axis_m_valid = rx_valid_q;
  assign rx_axis_m_last  = rx_last_q;
  assign sr_tx_underflow_cnt = uf_q;
  assign sr_rx_overflow_cnt  = of_q;
  assign sr_tx_last_err      = err_q;
  assign unused_data_c = ^{1'b0, tx_axis_s_data};

  assign frame_end_c = cr_enable && (cnt_q == CNT_W'(FRAME_C - 1));
  assign hs_tx_c = tx_axis_s_valid && ready_q;
  assign hs_rx_c = rx_valid_q && rx_axis_m_ready;

  // Frame counter, buffer hand-off and AXIS next-state logic.
  always_comb begin
    cnt_nxt       = (!cr_enable || frame_end_c) ? '0 : cnt_q + CNT_W'(1);
    just_nxt      = frame_end_c ? cr_left_justified : just_q;
    tx_l_nxt      = tx_l_q;
    tx_r_nxt      = tx_r_q;
    pend_l_nxt    = pend_l_q;
    pend_r_nxt    = pend_r_q;
    pend_full_nxt = pend_full_q;
    beat_nxt      = beat_q;
    uf_nxt        = uf_q;
    of_nxt        = of_q;
    err_nxt       = err_q;
    rx_data_nxt   = rx_data_q;
    rx_hold_nxt   = rx_hold_q;
    rx_valid_nxt  = rx_valid_q;
    rx_last_nxt   = rx_last_q;

    // TX boundary: take the pending packet or handle underflow.
    if (frame_end_c) begin
      if (pend_full_q) begin
        tx_l_nxt      = pend_l_q;
        tx_r_nxt      = pend_r_q;
        pend_full_nxt = 1'b0;
      end else begin
        uf_nxt = sat_inc(uf_q);
        if (!TX_HOLD_P) begin
          tx_l_nxt = '0;
          tx_r_nxt = '0;
        end
      end
    end

    // TX AXIS: beat toggle steers left then right; tlast only checked.
    if (hs_tx_c) begin
      if (!beat_q) begin
        pend_l_nxt = tx_axis_s_data[AW-1:0];
      end else begin
        pend_r_nxt    = tx_axis_s_data[AW-1:0];
        pend_full_nxt = 1'b1;
      end
      beat_nxt = ~beat_q;
      if (tx_axis_s_last != beat_q) err_nxt = 1'b1;
    end

    // Timing decode for the upcoming cycle drives the registered pins.
    ph_n      = 32'(cnt_nxt) % SCLK_DIV_P;
    b_n       = 32'(cnt_nxt) / SCLK_DIV_P;
    s_n       = b_n % SLOT_BITS_P;
    d_n       = just_nxt ? 32'd0 : 32'd1;
    win_n     = (s_n >= d_n) && (s_n < d_n + AW);
    idx_n     = win_n ? (AW - 1 - (s_n - d_n)) : 32'd0;
    tx_word_n = (b_n >= SLOT_BITS_P) ? tx_r_nxt : tx_l_nxt;
    tx_bit_n  = win_n && tx_word_n[IDX_W'(idx_n)];
    sclk_nxt  = cr_enable && (ph_n >= SCLK_DIV_P / 2);
    lrck_nxt  = cr_enable && (b_n >= SLOT_BITS_P);
    sdout_nxt = !cr_enable ? 1'b0 : ((ph_n == 0) ? tx_bit_n : sdout_q);

    // RX sampling uses the current cycle's position.
    ph_q       = 32'(cnt_q) % SCLK_DIV_P;
    b_q        = 32'(cnt_q) / SCLK_DIV_P;
    s_q        = b_q % SLOT_BITS_P;
    d_q        = just_q ? 32'd0 : 32'd1;
    win_q      = (s_q >= d_q) && (s_q < d_q + AW);
    rx_shift_c = cr_enable && (ph_q == SCLK_DIV_P - 1) && win_q;
    rx_l_nxt   = (rx_shift_c && (b_q < SLOT_BITS_P)) ?
                 {rx_l_q[AW-2:0], rx_sync_q[1]} : rx_l_q;
    rx_r_nxt   = (rx_shift_c && (b_q >= SLOT_BITS_P)) ?
                 {rx_r_q[AW-2:0], rx_sync_q[1]} : rx_r_q;

    // RX AXIS: left beat then right beat.
    if (hs_rx_c) begin
      if (!rx_last_q) begin
        rx_last_nxt = 1'b1;
        rx_data_nxt = rx_hold_q;
      end else begin
        rx_valid_nxt = 1'b0;
        rx_last_nxt  = 1'b0;
      end
    end

    // RX boundary: publish the frame or count it as dropped.
    if (frame_end_c) begin
      if (!rx_valid_q) begin
        rx_data_nxt  = sext(rx_l_nxt);
        rx_hold_nxt  = sext(rx_r_nxt);
        rx_valid_nxt = 1'b1;
        rx_last_nxt  = 1'b0;
      end else begin
        of_nxt = sat_inc(of_q);
      end
    end

    // Clear has priority over any increment in the same cycle.
    if (cr_clear_status) begin
      uf_nxt  = '0;
      of_nxt  = '0;
      err_nxt = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk_mclk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      just_q      <= 1'b0;
      sclk_q      <= 1'b0;
      lrck_q      <= 1'b0;
      sdout_q     <= 1'b0;
      rx_sync_q   <= '0;
      tx_l_q      <= '0;
      tx_r_q      <= '0;
      pend_l_q    <= '0;
      pend_r_q    <= '0;
      pend_full_q <= 1'b0;
      beat_q      <= 1'b0;
      ready_q     <= 1'b0;
      rx_l_q      <= '0;
      rx_r_q      <= '0;
      rx_data_q   <= '0;
      rx_hold_q   <= '0;
      rx_valid_q  <= 1'b0;
      rx_last_q   <= 1'b0;
      uf_q        <= '0;
      of_q        <= '0;
      err_q       <= 1'b0;
    end else begin
      cnt_q       <= cnt_nxt;
      just_q      <= just_nxt;
      sclk_q      <= sclk_nxt;
      lrck_q      <= lrck_nxt;
      sdout_q     <= sdout_nxt;
      rx_sync_q   <= {rx_sync_q[0], rx_sdin};
      tx_l_q      <= tx_l_nxt;
      tx_r_q      <= tx_r_nxt;
      pend_l_q    <= pend_l_nxt;
      pend_r_q    <= pend_r_nxt;
      pend_full_q <= pend_full_nxt;
      beat_q      <= beat_nxt;
      ready_q     <= !pend_full_nxt;
      rx_l_q      <= rx_l_nxt;
      rx_r_q      <= rx_r_nxt;
      rx_data_q   <= rx_data_nxt;
      rx_hold_q   <= rx_hold_nxt;
      rx_valid_q  <= rx_valid_nxt;
      rx_last_q   <= rx_last_nxt;
      uf_q        <= uf_nxt;
      of_q        <= of_nxt;
      err_q       <= err_nxt;
    end
  end

endmodule

// File: tb/tb_i2s_axis_codec.sv
// Scoreboard bench for i2s_axis_codec with tx_sdout looped back to rx_sdin.
module tb_i2s_axis_codec;

  localparam int unsigned DIV   = 8;
  localparam int unsigned FRAME = 512;

  logic        clk_mclk = 1'b0;
  logic        rst = 1'b1;
  logic        cr_enable = 1'b0, cr_left_justified = 1'b0, cr_clear_status = 1'b0;
  logic        tx_mclk, rx_mclk, tx_sclk, rx_sclk, tx_lrck, rx_lrck, tx_sdout;
  logic        rx_sdin;
  logic [31:0] tx_axis_s_data = '0;
  logic        tx_axis_s_valid = 1'b0, tx_axis_s_last = 1'b0, tx_axis_s_ready;
  logic [31:0] rx_axis_m_data;
  logic        rx_axis_m_valid, rx_axis_m_last;
  logic        rx_axis_m_ready = 1'b1;
  logic [15:0] sr_tx_underflow_cnt, sr_rx_overflow_cnt;
  logic        sr_tx_last_err;

  always #5 clk_mclk = ~clk_mclk;
  assign rx_sdin = tx_sdout;

  i2s_axis_codec dut (
    .clk_mclk(clk_mclk), .rst(rst), .cr_enable(cr_enable),
    .cr_left_justified(cr_left_justified), .cr_clear_status(cr_clear_status),
    .tx_mclk(tx_mclk), .rx_mclk(rx_mclk), .tx_sclk(tx_sclk), .rx_sclk(rx_sclk),
    .tx_lrck(tx_lrck), .rx_lrck(rx_lrck), .tx_sdout(tx_sdout), .rx_sdin(rx_sdin),
    .tx_axis_s_data(tx_axis_s_data), .tx_axis_s_valid(tx_axis_s_valid),
    .tx_axis_s_ready(tx_axis_s_ready), .tx_axis_s_last(tx_axis_s_last),
    .rx_axis_m_data(rx_axis_m_data), .rx_axis_m_valid(rx_axis_m_valid),
    .rx_axis_m_ready(rx_axis_m_ready), .rx_axis_m_last(rx_axis_m_last),
    .sr_tx_underflow_cnt(sr_tx_underflow_cnt), .sr_rx_overflow_cnt(sr_rx_overflow_cnt),
    .sr_tx_last_err(sr_tx_last_err)
  );

  typedef struct {
    logic [23:0] l;
    logic [23:0] r;
    bit          lj;
    bit          rx;
  } frame_t;

  frame_t      frame_q[$];
  logic [32:0] rx_q[$];
  int          checks = 0;
  int          errors = 0;
  int          frames_done = 0;
  int          clk_bad = 0;
  int unsigned tb_cnt;
  logic [63:0] cap;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] slot(input logic [23:0] s, input bit lj);
    return lj ? {s, 8'h00} : {1'b0, s, 7'h00};
  endfunction

  function automatic logic [31:0] sx(input logic [23:0] s);
    return {{8{s[23]}}, s};
  endfunction

  task automatic push_frame(input logic [23:0] l, input logic [23:0] r, input bit lj, input bit rx);
    frame_t f;
    f.l = l; f.r = r; f.lj = lj; f.rx = rx;
    frame_q.push_back(f);
  endtask

  // Reference frame position.
  always @(posedge clk_mclk or posedge rst) begin
    if (rst) tb_cnt <= 0;
    else if (!cr_enable) tb_cnt <= 0;
    else tb_cnt <= (tb_cnt == FRAME - 1) ? 0 : tb_cnt + 1;
  end

  // Capture the serial frame and compare it at each frame end.
  always @(negedge clk_mclk) begin
    frame_t f;
    if (!rst && cr_enable) begin
      if (tx_sclk !== ((tb_cnt % DIV) >= DIV / 2) || rx_sclk !== tx_sclk) clk_bad++;
      if (tx_lrck !== (tb_cnt >= FRAME / 2) || rx_lrck !== tx_lrck) clk_bad++;
      if (tb_cnt % DIV == DIV / 2) cap[6'(63 - tb_cnt / DIV)] = tx_sdout;
      if (tb_cnt == FRAME - 1) begin
        if (frame_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL frame_unexpected: frame %0d ended with no expectation", frames_done);
        end else begin
          f = frame_q.pop_front();
          check("tx_left_slot", cap[63:32], slot(f.l, f.lj));
          check("tx_right_slot", cap[31:0], slot(f.r, f.lj));
          check("sclk_lrck_errs", 32'(clk_bad), 32'd0);
          if (f.rx) begin
            rx_q.push_back({1'b0, sx(f.l)});
            rx_q.push_back({1'b1, sx(f.r)});
          end
        end
        clk_bad = 0;
        frames_done++;
      end
    end
  end

  // RX monitor: pop and compare on every completed handshake.
  always @(negedge clk_mclk) begin
    logic [32:0] e;
    if (!rst && rx_axis_m_valid && rx_axis_m_ready) begin
      if (rx_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL rx_unexpected: data 0x%08h last %0b with empty scoreboard",
                 rx_axis_m_data, rx_axis_m_last);
      end else begin
        e = rx_q.pop_front();
        check("rx_data", rx_axis_m_data, e[31:0]);
        check("rx_last", 32'(rx_axis_m_last), 32'(e[32]));
      end
    end
  end

  task automatic send_beat(input logic [31:0] d, input logic l);
    int n = 0;
    tx_axis_s_data  = d;
    tx_axis_s_last  = l;
    tx_axis_s_valid = 1'b1;
    @(negedge clk_mclk);
    while (!tx_axis_s_ready && n < 2000) begin
      @(negedge clk_mclk);
      n++;
    end
    if (!tx_axis_s_ready) begin
      checks++; errors++;
      $display("FAIL tx_handshake_timeout: ready 0 expected 1");
    end
    @(posedge clk_mclk); #2;
    tx_axis_s_valid = 1'b0;
  endtask

  task automatic wait_frames(input int n);
    int budget = 0;
    while (frames_done < n && budget < 6 * FRAME) begin
      @(posedge clk_mclk); #2;
      budget++;
    end
    if (frames_done < n) begin
      checks++; errors++;
      $display("FAIL frame_wait_timeout: frames %0d expected %0d", frames_done, n);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, 32'(tx_axis_s_ready), 32'd0);
    check({tag, "_clk_pins"}, 32'({tx_sclk, rx_sclk, tx_lrck, rx_lrck, tx_sdout}), 32'd0);
    check({tag, "_rx_flags"}, 32'({rx_axis_m_valid, rx_axis_m_last}), 32'd0);
    check({tag, "_rx_data"}, rx_axis_m_data, 32'd0);
    check({tag, "_status"}, {sr_tx_underflow_cnt, sr_rx_overflow_cnt}, 32'd0);
    check({tag, "_last_err"}, 32'(sr_tx_last_err), 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk_mclk);
    check_all_zero("reset");
    @(posedge clk_mclk); #2;
    rst = 1'b0;
    @(negedge clk_mclk);
    check("ready_before_first_clk", 32'(tx_axis_s_ready), 32'd0);
    @(posedge clk_mclk); #2;
    check("ready_after_release", 32'(tx_axis_s_ready), 32'd1);

    // I2S frames: silence, then packet A, then two held repeats.
    send_beat(32'h00A5A5A5, 1'b0);
    send_beat(32'h005A5A5A, 1'b1);
    check("ready_when_full", 32'(tx_axis_s_ready), 32'd0);
    push_frame(24'h000000, 24'h000000, 1'b0, 1'b1);
    push_frame(24'hA5A5A5, 24'h5A5A5A, 1'b0, 1'b1);
    push_frame(24'hA5A5A5, 24'h5A5A5A, 1'b0, 1'b1);
    push_frame(24'hA5A5A5, 24'h5A5A5A, 1'b0, 1'b1);
    cr_enable = 1'b1;
    wait_frames(3);
    check("underflow_after_2", 32'(sr_tx_underflow_cnt), 32'd2);
    check("last_err_clean", 32'(sr_tx_last_err), 32'd0);

    // Sign-extension packet B, I2S then left-justified.
    send_beat(32'h00800001, 1'b0);
    send_beat(32'h007FFFFF, 1'b1);
    push_frame(24'h800001, 24'h7FFFFF, 1'b0, 1'b1);
    wait_frames(4);
    cr_left_justified = 1'b1;
    send_beat(32'h00800001, 1'b0);
    send_beat(32'h007FFFFF, 1'b1);
    push_frame(24'h800001, 24'h7FFFFF, 1'b1, 1'b1);

    // Back-pressure for three frames.
    wait_frames(6);
    repeat (4) @(posedge clk_mclk);
    #2;
    rx_axis_m_ready = 1'b0;
    push_frame(24'h800001, 24'h7FFFFF, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) push_frame(24'h800001, 24'h7FFFFF, 1'b1, 1'b0);
    wait_frames(9);
    check("overflow_after_2", 32'(sr_rx_overflow_cnt), 32'd2);
    check("rx_valid_held", 32'(rx_axis_m_valid), 32'd1);
    check("rx_data_frozen", rx_axis_m_data, 32'hFF800001);
    wait_frames(10);
    check("overflow_after_3", 32'(sr_rx_overflow_cnt), 32'd3);
    check("rx_data_still_frozen", rx_axis_m_data, 32'hFF800001);
    check("rx_last_held", 32'(rx_axis_m_last), 32'd0);
    check("underflow_total", 32'(sr_tx_underflow_cnt), 32'd7);
    rx_axis_m_ready = 1'b1;
    repeat (4) @(posedge clk_mclk);
    #2;
    check("rx_drained", 32'(rx_axis_m_valid), 32'd0);

    // Status clear.
    cr_clear_status = 1'b1;
    @(posedge clk_mclk); #2;
    cr_clear_status = 1'b0;
    check("clear_counters", {sr_tx_underflow_cnt, sr_rx_overflow_cnt}, 32'd0);

    // tlast on both beats flags the parity error.
    send_beat(32'h00111111, 1'b1);
    send_beat(32'h00222222, 1'b1);
    check("last_err_set", 32'(sr_tx_last_err), 32'd1);
    check("rx_scoreboard_empty", 32'(rx_q.size()), 32'd0);
    check("frame_queue_empty", 32'(frame_q.size()), 32'd0);

    // Mid-frame reset.
    rst = 1'b1;
    cr_enable = 1'b0;
    cr_left_justified = 1'b0;
    @(negedge clk_mclk);
    check_all_zero("midframe_reset");
    @(posedge clk_mclk); #2;
    rst = 1'b0;
    @(negedge clk_mclk);
    check("ready_before_first_clk2", 32'(tx_axis_s_ready), 32'd0);
    @(posedge clk_mclk); #2;
    check("ready_after_release2", 32'(tx_axis_s_ready), 32'd1);

    // A half packet is discarded by reset and the beat toggle restarts.
    send_beat(32'h00333333, 1'b0);
    rst = 1'b1;
    @(posedge clk_mclk); #2;
    rst = 1'b0;
    @(posedge clk_mclk); #2;
    send_beat(32'h00444444, 1'b0);
    check("toggle_reset_no_err", 32'(sr_tx_last_err), 32'd0);
    check("toggle_reset_not_full", 32'(tx_axis_s_ready), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
